// File: rtl/si5340_cfg_sequencer.sv
// Si5340 bring-up sequencer: drives the single-register I2C config loader
// through a write pass, optional readback-verify pass, with cal delay and gaps.
module si5340_cfg_sequencer #(
  parameter int NUM_REGS      = 16,
  parameter int PREAMBLE_LEN  = 3,
  parameter int CAL_DELAY_CYC = 1000,
  parameter int GAP_CYC       = 4,
  parameter int VERIFY        = 1,
  parameter int TIMEOUT_CYC   = 65535
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic                        load_o,
  output logic                        write_o,
  input  logic                        ldr_done_i,
  input  logic [7:0]                  rd_data_i,
  input  logic [7:0]                  exp_data_i,
  output logic [$clog2(NUM_REGS)-1:0] idx_o,
  output logic [7:0]                  mism_cnt_o,
  output logic [$clog2(NUM_REGS)-1:0] err_idx_o
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int DMAX =
    (CAL_DELAY_CYC > GAP_CYC) ? CAL_DELAY_CYC : GAP_CYC;
  localparam int DW = $clog2(DMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
  localparam logic [IW-1:0] PRE_LAST =
    IW'((PREAMBLE_LEN == 0) ? 0 : PREAMBLE_LEN - 1);
  localparam bit HAS_CAL = (PREAMBLE_LEN != 0);
  localparam bit DO_VER  = (VERIFY != 0);

  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYC - 1);
  localparam logic [DW-1:0] CAL_LAST = DW'(CAL_DELAY_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_ISSUE,
    S_W_WAIT,
    S_GAP,
    S_CAL,
    S_V_ISSUE,
    S_V_WAIT,
    S_FIN,
    S_FAULT
  } state_t;

  state_t        state;
  logic          vpass;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] wcnt;
  logic          mism;

  assign mism = (rd_data_i != exp_data_i);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= S_IDLE;
      vpass      <= 1'b0;
      dcnt       <= '0;
      wcnt       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      load_o     <= 1'b0;
      write_o    <= 1'b0;
      idx_o      <= '0;
      mism_cnt_o <= '0;
      err_idx_o  <= '0;
    end else begin
      load_o <= 1'b0;
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            mism_cnt_o <= '0;
            err_idx_o  <= '0;
            error_o    <= 1'b0;
            idx_o      <= '0;
            vpass      <= 1'b0;
            busy_o     <= 1'b1;
            load_o     <= 1'b1;
            write_o    <= 1'b1;
            state      <= S_W_ISSUE;
          end
        end
        S_W_ISSUE: begin
          wcnt  <= '0;
          state <= S_W_WAIT;
        end
        S_W_WAIT: begin
          if (ldr_done_i) begin
            dcnt <= '0;
            if (idx_o == LAST_IDX) begin
              idx_o <= '0;
              if (DO_VER) begin
                // readback pass starts straight away, no gap
                vpass   <= 1'b1;
                load_o  <= 1'b1;
                write_o <= 1'b0;
                state   <= S_V_ISSUE;
              end else begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
                state  <= S_FIN;
              end
            end else if (HAS_CAL && idx_o == PRE_LAST) begin
              idx_o <= idx_o + 1'b1;
              state <= S_CAL;
            end else begin
              idx_o <= idx_o + 1'b1;
              state <= S_GAP;
            end
          end else if (wcnt == TO_LAST) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state   <= S_FAULT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (dcnt == GAP_LAST) begin
            load_o  <= 1'b1;
            write_o <= ~vpass;
            state   <= vpass ? S_V_ISSUE : S_W_ISSUE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_CAL: begin
          if (dcnt == CAL_LAST) begin
            load_o  <= 1'b1;
            write_o <= 1'b1;
            state   <= S_W_ISSUE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_V_ISSUE: begin
          wcnt  <= '0;
          state <= S_V_WAIT;
        end
        S_V_WAIT: begin
          if (ldr_done_i) begin
            dcnt <= '0;
            if (mism) begin
              error_o <= 1'b1;
              if (mism_cnt_o != 8'hFF) begin
                mism_cnt_o <= mism_cnt_o + 8'd1;
              end
              if (mism_cnt_o == 8'd0) begin
                err_idx_o <= idx_o;
              end
            end
            if (idx_o == LAST_IDX) begin
              idx_o  <= '0;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= S_FIN;
            end else begin
              idx_o <= idx_o + 1'b1;
              state <= S_GAP;
            end
          end else if (wcnt == TO_LAST) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state   <= S_FAULT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        // loader index sync is lost; only reset recovers
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Directed bench for si5340_cfg_sequencer: two instances (write-only and
// preamble+verify) driven by a loader model that acks 10 cycles after load.
module tb_si5340_cfg_sequencer;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  function automatic logic [7:0] f_tbl(input logic [1:0] i);
    case (i)
      2'd0: return 8'h3C;
      2'd1: return 8'h5A;
      2'd2: return 8'hC3;
      default: return 8'h81;
    endcase
  endfunction

  logic       start0, busy0, done0, err0, load0, wr0, ldone0;
  logic [7:0] rd0, exp0, mism0;
  logic [1:0] idx0, eidx0;
  logic       start1, busy1, done1, err1, load1, wr1, ldone1;
  logic [7:0] rd1, exp1, mism1;
  logic [1:0] idx1, eidx1;

  assign exp0 = f_tbl(idx0);
  assign exp1 = f_tbl(idx1);

  si5340_cfg_sequencer #(
    .NUM_REGS(4), .PREAMBLE_LEN(0), .CAL_DELAY_CYC(50),
    .GAP_CYC(4), .VERIFY(0), .TIMEOUT_CYC(100)
  ) u0 (
    .clk_i(clk), .arstn_i(arstn), .start_i(start0),
    .busy_o(busy0), .done_o(done0), .error_o(err0),
    .load_o(load0), .write_o(wr0), .ldr_done_i(ldone0),
    .rd_data_i(rd0), .exp_data_i(exp0), .idx_o(idx0),
    .mism_cnt_o(mism0), .err_idx_o(eidx0)
  );

  si5340_cfg_sequencer #(
    .NUM_REGS(4), .PREAMBLE_LEN(2), .CAL_DELAY_CYC(50),
    .GAP_CYC(4), .VERIFY(1), .TIMEOUT_CYC(100)
  ) u1 (
    .clk_i(clk), .arstn_i(arstn), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .error_o(err1),
    .load_o(load1), .write_o(wr1), .ldr_done_i(ldone1),
    .rd_data_i(rd1), .exp_data_i(exp1), .idx_o(idx1),
    .mism_cnt_o(mism1), .err_idx_o(eidx1)
  );

  bit       ack_en0, ack_en1;
  bit [3:0] corrupt1;
  logic [3:0] ac0, ac1;
  logic [1:0] mi0, mi1;

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ac0 <= '0; mi0 <= '0; ldone0 <= 1'b0; rd0 <= '0;
    end else begin
      ldone0 <= 1'b0;
      if (load0) ac0 <= 4'd9;
      else if (ac0 != 0) begin
        ac0 <= ac0 - 1'b1;
        if (ac0 == 4'd1 && ack_en0) begin
          ldone0 <= 1'b1;
          rd0    <= f_tbl(mi0);
          mi0    <= mi0 + 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ac1 <= '0; mi1 <= '0; ldone1 <= 1'b0; rd1 <= '0;
    end else begin
      ldone1 <= 1'b0;
      if (load1) ac1 <= 4'd9;
      else if (ac1 != 0) begin
        ac1 <= ac1 - 1'b1;
        if (ac1 == 4'd1 && ack_en1) begin
          ldone1 <= 1'b1;
          rd1    <= f_tbl(mi1) ^ (corrupt1[mi1] ? 8'hFF : 8'h00);
          mi1    <= mi1 + 1'b1;
        end
      end
    end
  end

  int lt0[$], lt1[$], dt1[$], dnt0[$];
  logic lw0[$], lw1[$];
  logic [1:0] li1[$];
  int dn0 = 0;
  int dn1 = 0;

  always @(negedge clk) begin
    if (load0) begin lt0.push_back(cyc); lw0.push_back(wr0); end
    if (done0) begin dnt0.push_back(cyc); dn0 <= dn0 + 1; end
    if (load1) begin
      lt1.push_back(cyc); lw1.push_back(wr1); li1.push_back(idx1);
    end
    if (ldone1) dt1.push_back(cyc);
    if (done1) dn1 <= dn1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input int u, input int maxc);
    int k = 0;
    while (((u == 0) ? done0 : done1) !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk((u == 0) ? "done0_seen" : "done1_seen",
        (u == 0) ? done0 : done1, 1);
  endtask

  initial begin
    int b, d, db, b2;
    start0 = 0; start1 = 0;
    ack_en0 = 1; ack_en1 = 1; corrupt1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_load", load0, 0);
    chk("rst_write", wr0, 0);
    chk("rst_idx", idx0, 0);
    chk("rst_mism", mism0, 0);
    chk("rst_eidx", eidx0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_load1", load1, 0);
    arstn = 1;
    @(negedge clk);

    // write-only pass, no preamble
    b = lt0.size(); d = dn0;
    start0 = 1; @(negedge clk); start0 = 0;
    chk("A_busy_t1", busy0, 1);
    chk("A_load_t1", load0, 1);
    chk("A_write_t1", wr0, 1);
    wait_done(0, 400);
    chk("A_busy_at_done", busy0, 0);
    @(negedge clk);
    chk("A_nloads", lt0.size() - b, 4);
    for (int i = 0; i < 4; i++) chk("A_write", lw0[b+i], 1);
    for (int i = 1; i < 4; i++)
      chk("A_spacing", lt0[b+i] - lt0[b+i-1], 15);
    chk("A_ndone", dn0 - d, 1);
    chk("A_err", err0, 0);
    chk("A_idx_end", idx0, 0);

    // preamble + calibration + clean verify
    b = lt1.size(); db = dt1.size(); d = dn1;
    start1 = 1; @(negedge clk); start1 = 0;
    wait_done(1, 700);
    chk("B_busy_at_done", busy1, 0);
    @(negedge clk);
    chk("B_nloads", lt1.size() - b, 8);
    for (int i = 0; i < 4; i++) chk("B_write", lw1[b+i], 1);
    for (int i = 4; i < 8; i++) chk("B_read", lw1[b+i], 0);
    chk("B_gap0", lt1[b+1] - dt1[db+0], 5);
    chk("B_cal", lt1[b+2] - dt1[db+1], 51);
    chk("B_gap2", lt1[b+3] - dt1[db+2], 5);
    chk("B_vgap", lt1[b+5] - dt1[db+4], 5);
    chk("B_err", err1, 0);
    chk("B_mism", mism1, 0);
    chk("B_ndone", dn1 - d, 1);
    chk("B_idx_end", idx1, 0);

    // verify with corrupted entries 1 and 3
    corrupt1 = 4'b1010;
    b = lt1.size(); d = dn1;
    start1 = 1; @(negedge clk); start1 = 0;
    chk("C_err_cleared", err1, 0);
    wait_done(1, 700);
    @(negedge clk);
    chk("C_nloads", lt1.size() - b, 8);
    chk("C_err", err1, 1);
    chk("C_mism", mism1, 2);
    chk("C_eidx", eidx1, 1);
    chk("C_ndone", dn1 - d, 1);
    corrupt1 = '0;

    // timeout then fault lock
    ack_en0 = 0;
    b = lt0.size(); db = dnt0.size(); d = dn0;
    start0 = 1; @(negedge clk); start0 = 0;
    wait_done(0, 300);
    chk("D_err", err0, 1);
    chk("D_busy", busy0, 0);
    @(negedge clk);
    chk("D_latency", dnt0[db] - lt0[b], 101);
    start0 = 1; @(negedge clk); start0 = 0;
    repeat (30) @(negedge clk);
    chk("D_nloads", lt0.size() - b, 1);
    chk("D_ndone", dn0 - d, 1);
    chk("D_busy_fault", busy0, 0);
    chk("D_err_sticky", err0, 1);
    arstn = 0;
    repeat (2) @(negedge clk);
    chk("D_rst_err", err0, 0);
    chk("D_rst_busy", busy0, 0);
    chk("D_rst_done", done0, 0);
    chk("D_rst_load", load0, 0);
    chk("D_rst_idx", idx0, 0);
    arstn = 1; ack_en0 = 1;
    @(negedge clk);

    // ignored start while busy, reset mid-wait, restart
    b = lt1.size();
    start1 = 1; @(negedge clk); start1 = 0;
    chk("E_busy", busy1, 1);
    repeat (2) @(negedge clk);
    start1 = 1; @(negedge clk); start1 = 0;
    repeat (2) @(negedge clk);
    chk("E_nloads_ign", lt1.size() - b, 1);
    arstn = 0;
    @(negedge clk);
    chk("E_rst_busy", busy1, 0);
    chk("E_rst_idx", idx1, 0);
    arstn = 1;
    repeat (20) @(negedge clk);
    chk("E_nloads_idle", lt1.size() - b, 1);
    b2 = lt1.size(); d = dn1;
    start1 = 1; @(negedge clk); start1 = 0;
    wait_done(1, 700);
    @(negedge clk);
    chk("E_first_idx", li1[b2], 0);
    chk("E_nloads", lt1.size() - b2, 8);
    chk("E_err", err1, 0);
    chk("E_mism", mism1, 0);
    chk("E_ndone", dn1 - d, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
